ffn_pipe: RTL and testbench

// - Parametrised successor to the fixed 8-bit flip-flop bank.
// - WIDTH-bit, DEPTH-stage elastic register pipeline with a valid/ready handshake per word.
// - Stages are bubble-collapsing; adds synchronous flush and an occupancy count.
// - Sits between neuron sequencing blocks to retime buses and absorb downstream stalls.

---
 rtl/ffn_pipe.sv | 123 ++++++++++++
 tb/tb_ffn_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ffn_pipe.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready handshake, bubble collapse,
// synchronous flush and occupancy count. Optional scan chain when FFN_SCAN_EN is defined.
module ffn_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] D,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Q,
  input  logic             FLUSH,
  output logic [OCC_W-1:0] OCC
`ifdef FFN_SCAN_EN
  ,
  input  logic             SE,
  input  logic             SI,
  output logic             SO
`endif
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] r [DEPTH];
  logic [OCC_W-1:0] occ_q;

  logic [DEPTH-1:0] adv;
  logic             tail_full;
  logic [DEPTH:0]   vin;
  logic [WIDTH-1:0] din [DEPTH];
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [DEPTH-1:0] r_en;
  logic             scan_mode;

  function automatic logic [OCC_W-1:0] popcnt(input logic [DEPTH-1:0] x);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + OCC_W'(x[i]);
    return c;
  endfunction

  // adv[i] is true when some stage at or after i is empty, or the output drains
  always_comb begin
    tail_full = 1'b1;
    adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & v[i];
      adv[i] = ~tail_full | OUT_READY;
    end
  end

  assign vin = {v, IN_VALID};

  always_comb begin
    din[0] = D;
    for (int i = 1; i < DEPTH; i++) din[i] = r[i-1];
  end

`ifdef FFN_SCAN_EN
  localparam int NCH = DEPTH * (WIDTH + 1);
  logic [NCH-1:0] ch;
  logic [NCH-1:0] ch_sh;

  always_comb begin
    ch = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ch[i*(WIDTH+1)] = v[i];
      ch[i*(WIDTH+1)+1 +: WIDTH] = r[i];
    end
  end

  assign ch_sh     = {ch[NCH-2:0], SI};
  assign SO        = ch[NCH-1];
  assign scan_mode = SE;
`else
  assign scan_mode = 1'b0;
`endif

  always_comb begin
    v_d  = v;
    r_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      r_d[i] = din[i];
      if (adv[i]) v_d[i] = vin[i];
      // data only moves with a valid word, and flush leaves data untouched
      r_en[i] = adv[i] & vin[i] & ~FLUSH;
    end
    if (FLUSH) v_d = '0;
`ifdef FFN_SCAN_EN
    if (SE) begin
      for (int i = 0; i < DEPTH; i++) begin
        v_d[i] = ch_sh[i*(WIDTH+1)];
        r_d[i] = ch_sh[i*(WIDTH+1)+1 +: WIDTH];
      end
      r_en = '1;
    end
`endif
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      v     <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) r[i] <= '0;
    end else begin
      v     <= v_d;
      occ_q <= popcnt(v_d);
      for (int i = 0; i < DEPTH; i++) begin
        if (r_en[i]) r[i] <= r_d[i];
      end
    end
  end

  assign IN_READY  = adv[0] & ~scan_mode;
  assign OUT_VALID = v[DEPTH-1] & ~scan_mode;
  assign Q         = r[DEPTH-1];
  assign OCC       = occ_q;

endmodule

// File: tb/tb_ffn_pipe.sv
// Directed self-checking bench for ffn_pipe (WIDTH=8, DEPTH=4); scan test only when FFN_SCAN_EN is defined.
module tb_ffn_pipe;
  localparam int W  = 8;
  localparam int DP = 4;

  logic         CK;
  logic         RN;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] D;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] Q;
  logic         FLUSH;
  logic [2:0]   OCC;
`ifdef FFN_SCAN_EN
  logic         SE;
  logic         SI;
  logic         SO;
`endif

  int checks;
  int errors;

  ffn_pipe #(.WIDTH(W), .DEPTH(DP)) dut (
    .CK(CK), .RN(RN), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .D(D),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .Q(Q), .FLUSH(FLUSH), .OCC(OCC)
`ifdef FFN_SCAN_EN
    , .SE(SE), .SI(SI), .SO(SO)
`endif
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    RN = 1'b0; IN_VALID = 1'b0; D = '0; OUT_READY = 1'b0; FLUSH = 1'b0;
`ifdef FFN_SCAN_EN
    SE = 1'b0; SI = 1'b0;
`endif
    #3;
    checks++;
    if (Q !== 8'h00 || OUT_VALID !== 1'b0 || OCC !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: Q=%h OUT_VALID=%b OCC=%0d, want 00 0 0", Q, OUT_VALID, OCC);
    end
    tick();
    RN = 1'b1;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", IN_READY);
    end
  endtask

  task automatic test_stream();
    OUT_READY = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      IN_VALID = (e <= 16);
      D = W'(e);
      #1;
      if (e <= 16) begin
        checks++;
        if (IN_READY !== 1'b1) begin
          errors++;
          $display("FAIL stream_in_ready e=%0d: got %b want 1", e, IN_READY);
        end
      end
      tick();
      checks++;
      if (e >= 4 && e <= 19) begin
        if (OUT_VALID !== 1'b1 || Q !== W'(e - 3)) begin
          errors++;
          $display("FAIL stream_out e=%0d: OUT_VALID=%b Q=%h want 1 %h", e, OUT_VALID, Q, W'(e - 3));
        end
      end else if (e < 4) begin
        if (OUT_VALID !== 1'b0) begin
          errors++;
          $display("FAIL stream_latency e=%0d: OUT_VALID=%b want 0", e, OUT_VALID);
        end
      end else begin
        if (OUT_VALID !== 1'b0 || Q !== 8'h10 || OCC !== 3'd0) begin
          errors++;
          $display("FAIL stream_empty_hold: OUT_VALID=%b Q=%h OCC=%0d want 0 10 0", OUT_VALID, Q, OCC);
        end
      end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_q [6];
    int acc;
    int emitted;
    for (int i = 0; i < 6; i++) exp_q[i] = 8'hA0 + W'(i);
    acc = 0;
    emitted = 0;
    OUT_READY = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      IN_VALID = 1'b1;
      D = exp_q[acc];
      #1;
      if (IN_READY) acc++;
      tick();
      checks++;
      if (OCC !== 3'(c < 4 ? c : 4)) begin
        errors++;
        $display("FAIL bp_occ c=%0d: got %0d want %0d", c, OCC, (c < 4 ? c : 4));
      end
    end
    #1;
    checks++;
    if (acc != 4 || IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || Q !== 8'hA0) begin
      errors++;
      $display("FAIL bp_full: accepted=%0d IN_READY=%b OUT_VALID=%b Q=%h want 4 0 1 a0", acc, IN_READY, OUT_VALID, Q);
    end
    OUT_READY = 1'b1;
    for (int c = 0; c < 12; c++) begin
      IN_VALID = (acc < 6);
      D = (acc < 6) ? exp_q[acc] : 8'h00;
      #1;
      if (OUT_VALID) begin
        checks++;
        if (emitted >= 6 || Q !== exp_q[emitted]) begin
          errors++;
          $display("FAIL bp_order idx=%0d: got %h want %h", emitted, Q, (emitted < 6) ? exp_q[emitted] : 8'hxx);
        end
        emitted++;
      end
      if (IN_VALID && IN_READY) acc++;
      tick();
    end
    IN_VALID = 1'b0;
    checks++;
    if (emitted != 6 || OCC !== 3'd0) begin
      errors++;
      $display("FAIL bp_count: emitted=%0d OCC=%0d want 6 0", emitted, OCC);
    end
  endtask

  task automatic test_full_simultaneous();
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1;
      D = 8'hB0 + W'(i);
      tick();
    end
    checks++;
    if (OCC !== 3'd4 || Q !== 8'hB0) begin
      errors++;
      $display("FAIL full_fill: OCC=%0d Q=%h want 4 b0", OCC, Q);
    end
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1;
      D = 8'hB4 + W'(i);
      #1;
      checks++;
      if (IN_READY !== 1'b1 || OUT_VALID !== 1'b1 || Q !== 8'hB0 + W'(i)) begin
        errors++;
        $display("FAIL full_xfer i=%0d: IN_READY=%b OUT_VALID=%b Q=%h want 1 1 %h", i, IN_READY, OUT_VALID, Q, 8'hB0 + W'(i));
      end
      tick();
      checks++;
      if (OCC !== 3'd4) begin
        errors++;
        $display("FAIL full_occ i=%0d: got %0d want 4", i, OCC);
      end
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    #1;
    checks++;
    if (Q !== 8'hB3) begin
      errors++;
      $display("FAIL full_next: Q=%h want b3", Q);
    end
  endtask

  task automatic test_flush();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    checks++;
    if (OCC !== 3'd0 || OUT_VALID !== 1'b0 || Q !== 8'hB3) begin
      errors++;
      $display("FAIL flush_full: OCC=%0d OUT_VALID=%b Q=%h want 0 0 b3", OCC, OUT_VALID, Q);
    end
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1;
      D = 8'hC0 + W'(i);
      tick();
    end
    checks++;
    if (OCC !== 3'd3 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL flush_prefill: OCC=%0d OUT_VALID=%b want 3 0", OCC, OUT_VALID);
    end
    FLUSH = 1'b1;
    IN_VALID = 1'b1;
    D = 8'h55;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL flush_in_ready: got %b want 1", IN_READY);
    end
    tick();
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    checks++;
    if (OCC !== 3'd0 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: OCC=%0d OUT_VALID=%b want 0 0", OCC, OUT_VALID);
    end
    OUT_READY = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (OUT_VALID !== 1'b0 || Q !== 8'hB3) begin
        errors++;
        $display("FAIL flush_drop c=%0d: OUT_VALID=%b Q=%h want 0 b3", c, OUT_VALID, Q);
      end
    end
  endtask

  task automatic test_reset_midstream();
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1;
      D = 8'hD0 + W'(i);
      tick();
    end
    IN_VALID = 1'b0;
    tick();
    checks++;
    if (OCC !== 3'd3 || OUT_VALID !== 1'b1 || Q !== 8'hD0) begin
      errors++;
      $display("FAIL midreset_pre: OCC=%0d OUT_VALID=%b Q=%h want 3 1 d0", OCC, OUT_VALID, Q);
    end
    RN = 1'b0;
    #2;
    checks++;
    if (OCC !== 3'd0 || OUT_VALID !== 1'b0 || Q !== 8'h00) begin
      errors++;
      $display("FAIL midreset_async: OCC=%0d OUT_VALID=%b Q=%h want 0 0 00", OCC, OUT_VALID, Q);
    end
    #2;
    RN = 1'b1;
    tick();
  endtask

`ifdef FFN_SCAN_EN
  task automatic test_scan();
    logic [DP*(W+1)-1:0] ch;
    ch = {1'b0, 8'hC3, 1'b1, 8'h5A, 1'b1, 8'h11, 1'b0, 8'h3C, 1'b1};
    ch[27] = 1'b1;
    ch[18] = 1'b1;
    ch[9]  = 1'b0;
    ch[0]  = 1'b1;
    ch[35:28] = 8'hC3;
    ch[26:19] = 8'h5A;
    ch[17:10] = 8'h11;
    ch[8:1]   = 8'h3C;
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    SE = 1'b1;
    for (int k = DP*(W+1) - 1; k >= 0; k--) begin
      SI = ch[k];
      tick();
    end
    checks++;
    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL scan_freeze: IN_READY=%b OUT_VALID=%b want 0 0", IN_READY, OUT_VALID);
    end
    IN_VALID = 1'b0;
    SE = 1'b0;
    #1;
    checks++;
    if (OCC !== 3'd3 || OUT_VALID !== 1'b1 || Q !== 8'hC3 || SO !== 1'b1) begin
      errors++;
      $display("FAIL scan_load: OCC=%0d OUT_VALID=%b Q=%h SO=%b want 3 1 c3 1", OCC, OUT_VALID, Q, SO);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_simultaneous();
    test_flush();
    test_reset_midstream();
`ifdef FFN_SCAN_EN
    test_scan();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
